// File: rtl/fp_unpacker_pkg.sv
// Shared FPU format constants and the unpacked-operand record.
// Other FPU stages import this package to use the same operand layout.
package fp_unpacker_pkg;

  localparam int DBL_EXP_W  = 11;
  localparam int DBL_FRAC_W = 52;
  localparam int SGL_EXP_W  = 8;
  localparam int SGL_FRAC_W = 23;
  localparam int SIG_W      = 53;
  localparam int LZ_W       = 6;

  typedef struct packed {
    logic                  s;
    logic [DBL_EXP_W-1:0]  e;
    logic                  e_inf;
    logic                  e_z;
    logic [DBL_FRAC_W-1:0] h;
    logic                  fz;
    logic [SIG_W-1:0]      f;
    logic [LZ_W-1:0]       lz;
  } unpacked_t;

endpackage

// File: rtl/fp_unpacker_lzc53.sv
// 53-bit leading-zero counter, counting down from bit 52; all-zero input yields 53.
// Combinational, zero latency; no flow control.
module fp_unpacker_lzc53
  import fp_unpacker_pkg::*;
(
  input  logic [SIG_W-1:0] m,
  output logic [LZ_W-1:0]  lz
);

  logic found;

  always_comb begin
    lz    = LZ_W'(SIG_W);
    found = 1'b0;
    for (int i = SIG_W - 1; i >= 0; i--) begin
      if (!found && m[i]) begin
        lz    = LZ_W'(SIG_W - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_unpacker.sv
// IEEE-754 double/single operand decomposition; 1-cycle latency, 1 per cycle throughput.
// No backpressure: the output register loads on every clock edge.
module fp_unpacker
  import fp_unpacker_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] fp,
  input  logic        db,
  input  logic        normal,
  output logic        s,
  output logic [10:0] e,
  output logic        e_inf,
  output logic        e_z,
  output logic [51:0] h,
  output logic        fz,
  output logic [52:0] f,
  output logic [5:0]  lz
);

  logic [DBL_EXP_W-1:0]  exp_c;
  logic [DBL_FRAC_W-1:0] h_c;
  logic                  e_inf_c;
  logic                  e_z_c;
  logic [SIG_W-1:0]      m_c;
  logic [LZ_W-1:0]       lz_c;
  logic [SIG_W-1:0]      sh [0:LZ_W];
  unpacked_t             d_c;
  unpacked_t             q;

  always_comb begin
    if (db) begin
      exp_c   = fp[62:52];
      h_c     = fp[51:0];
      e_inf_c = &fp[62:52];
    end else begin
      exp_c   = {3'b000, fp[62:55]};
      h_c     = {fp[54:32], 29'b0};
      e_inf_c = &fp[62:55];
    end
    e_z_c = (exp_c == '0);
    m_c   = {~e_z_c, h_c};
  end

  fp_unpacker_lzc53 u_lzc (
    .m  (m_c),
    .lz (lz_c)
  );

  // Log-depth left shifter; a zero significand shifts to zero regardless of lz.
  assign sh[0] = m_c;
  for (genvar k = 0; k < LZ_W; k++) begin : g_shift
    assign sh[k+1] = lz_c[k] ? (sh[k] << (2 ** k)) : sh[k];
  end

  always_comb begin
    d_c.s     = fp[63];
    d_c.e     = exp_c;
    d_c.e_inf = e_inf_c;
    d_c.e_z   = e_z_c;
    d_c.h     = h_c;
    d_c.fz    = (h_c == '0);
    d_c.f     = normal ? sh[LZ_W] : m_c;
    d_c.lz    = lz_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d_c;
  end

  assign s     = q.s;
  assign e     = q.e;
  assign e_inf = q.e_inf;
  assign e_z   = q.e_z;
  assign h     = q.h;
  assign fz    = q.fz;
  assign f     = q.f;
  assign lz    = q.lz;

endmodule

// File: tb/tb_fp_unpacker.sv
// Self-checking bench for fp_unpacker: directed IEEE vectors, random operands
// against a behavioural model, back-to-back streaming and asynchronous reset.
module tb_fp_unpacker;

  logic        clk;
  logic        rst_n;
  logic [63:0] fp;
  logic        db;
  logic        normal;
  logic        s;
  logic [10:0] e;
  logic        e_inf;
  logic        e_z;
  logic [51:0] h;
  logic        fz;
  logic [52:0] f;
  logic [5:0]  lz;

  logic [125:0] got;
  assign got = {s, e, e_inf, e_z, h, fz, f, lz};

  int checks   = 0;
  int failures = 0;

  fp_unpacker dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .fp     (fp),
    .db     (db),
    .normal (normal),
    .s      (s),
    .e      (e),
    .e_inf  (e_inf),
    .e_z    (e_z),
    .h      (h),
    .fz     (fz),
    .f      (f),
    .lz     (lz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decode per the IEEE field layout, count zeros by scanning.
  function automatic logic [125:0] model(input logic [63:0] x, input logic dbl, input logic nrm);
    logic [10:0] ex;
    logic [51:0] fr;
    logic        inf, zr;
    logic [52:0] m, fo;
    int          n;
    if (dbl) begin
      ex  = x[62:52];
      fr  = x[51:0];
      inf = (ex == 11'h7FF);
    end else begin
      ex  = {3'b000, x[62:55]};
      fr  = {x[54:32], 29'b0};
      inf = (ex == 11'h0FF);
    end
    zr = (ex == 0);
    m  = {!zr, fr};
    n  = 53;
    for (int i = 0; i < 53; i++)
      if (n == 53 && m[52-i]) n = i;
    fo = nrm ? (m << n) : m;
    return {x[63], ex, inf, zr, fr, (fr == 0), fo, 6'(n)};
  endfunction

  function automatic logic [63:0] rand_operand(input logic dbl);
    logic [63:0] x;
    x = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) begin
      if (dbl) begin
        x[62:52] = '0;
        x[51:0]  = x[51:0] >> $urandom_range(0, 52);
      end else begin
        x[62:55] = '0;
        x[54:32] = x[54:32] >> $urandom_range(0, 23);
      end
    end else if ($urandom_range(0, 7) == 0) begin
      if (dbl) x[62:52] = 11'h7FF;
      else     x[62:55] = 8'hFF;
    end
    return x;
  endfunction

  task automatic apply(input logic [63:0] x, input logic dbl, input logic nrm);
    fp = x; db = dbl; normal = nrm;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    fp = 64'h3FF0000000000000; db = 1'b1; normal = 1'b0;
    rst_n = 1'b0;
    #2;
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", got);
    end
    @(posedge clk); #1;
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL reset_held got=%h exp=0", got);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [125:0] exp_v [10];
    logic [63:0]  xs    [10];
    logic         dbs   [10];
    logic         nrms  [10];
    xs[0] = {1'b0, 8'h7F, 23'b0, 32'b0};   dbs[0] = 0; nrms[0] = 0;
    exp_v[0] = {1'b0, 11'h07F, 1'b0, 1'b0, 52'h0, 1'b1, 53'h10000000000000, 6'd0};
    xs[1] = {1'b0, 8'h00, 23'd1, 32'b0};   dbs[1] = 0; nrms[1] = 0;
    exp_v[1] = {1'b0, 11'h000, 1'b0, 1'b1, 52'h0000020000000, 1'b0, 53'h00000020000000, 6'd23};
    xs[2] = xs[1];                         dbs[2] = 0; nrms[2] = 1;
    exp_v[2] = {1'b0, 11'h000, 1'b0, 1'b1, 52'h0000020000000, 1'b0, 53'h10000000000000, 6'd23};
    xs[3] = 64'h7FF0000000000000;          dbs[3] = 1; nrms[3] = 0;
    exp_v[3] = {1'b0, 11'h7FF, 1'b1, 1'b0, 52'h0, 1'b1, 53'h10000000000000, 6'd0};
    xs[4] = 64'h7FF8000000000000;          dbs[4] = 1; nrms[4] = 0;
    exp_v[4] = {1'b0, 11'h7FF, 1'b1, 1'b0, 52'h8000000000000, 1'b0, 53'h18000000000000, 6'd0};
    xs[5] = 64'h8000000000000000;          dbs[5] = 1; nrms[5] = 1;
    exp_v[5] = {1'b1, 11'h000, 1'b0, 1'b1, 52'h0, 1'b1, 53'h0, 6'd53};
    xs[6] = 64'h8000000000000000;          dbs[6] = 0; nrms[6] = 1;
    exp_v[6] = exp_v[5];
    xs[7] = 64'hC0600000FFFFFFFF;          dbs[7] = 0; nrms[7] = 0;
    exp_v[7] = {1'b1, 11'h080, 1'b0, 1'b0, 52'hC000000000000, 1'b0, 53'h1C000000000000, 6'd0};
    xs[8] = 64'h7F800000FFFFFFFF;          dbs[8] = 0; nrms[8] = 1;
    exp_v[8] = {1'b0, 11'h0FF, 1'b1, 1'b0, 52'h0, 1'b1, 53'h10000000000000, 6'd0};
    xs[9] = 64'h0000000000000001;          dbs[9] = 1; nrms[9] = 1;
    exp_v[9] = {1'b0, 11'h000, 1'b0, 1'b1, 52'h0000000000001, 1'b0, 53'h10000000000000, 6'd52};
    for (int i = 0; i < 10; i++) begin
      apply(xs[i], dbs[i], nrms[i]);
      checks++;
      if (got !== exp_v[i]) begin
        failures++;
        $display("FAIL directed_%0d got=%h exp=%h", i, got, exp_v[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0]  x;
    logic         dbl, nrm;
    logic [125:0] ev;
    for (int i = 0; i < 300; i++) begin
      dbl = 1'($urandom_range(0, 1));
      nrm = 1'($urandom_range(0, 1));
      x   = rand_operand(dbl);
      ev  = model(x, dbl, nrm);
      apply(x, dbl, nrm);
      checks++;
      if (got !== ev) begin
        failures++;
        $display("FAIL random_%0d fp=%h db=%b normal=%b got=%h exp=%h", i, x, dbl, nrm, got, ev);
      end
    end
  endtask

  // New inputs are already on the pins when the previous result is checked.
  task automatic test_back_to_back();
    logic [125:0] q[$];
    logic [125:0] ev;
    logic         dbl, nrm;
    logic [63:0]  x;
    for (int i = 0; i < 100; i++) begin
      dbl = 1'($urandom_range(0, 1));
      nrm = 1'($urandom_range(0, 1));
      x   = rand_operand(dbl);
      q.push_back(model(x, dbl, nrm));
      fp = x; db = dbl; normal = nrm;
      if (i > 0) begin
        ev = q.pop_front();
        checks++;
        if (got !== ev) begin
          failures++;
          $display("FAIL b2b_%0d got=%h exp=%h", i, got, ev);
        end
      end
      @(posedge clk); #1;
    end
    ev = q.pop_front();
    checks++;
    if (got !== ev) begin
      failures++;
      $display("FAIL b2b_last got=%h exp=%h", got, ev);
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] x;
    x = 64'hC0600000FFFFFFFF;
    apply(x, 1'b0, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL midreset_async got=%h exp=0", got);
    end
    @(posedge clk); #1;
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL midreset_held got=%h exp=0", got);
    end
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL midreset_release_noedge got=%h exp=0", got);
    end
    @(posedge clk); #1;
    checks++;
    if (got !== model(x, 1'b0, 1'b1)) begin
      failures++;
      $display("FAIL midreset_first_load got=%h exp=%h", got, model(x, 1'b0, 1'b1));
    end
  endtask

  initial begin
    rst_n = 1'b0; fp = '0; db = 1'b0; normal = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_unpacker.md
# fp_unpacker

Combinational IEEE-754 operand decomposition with a single registered output stage, at the front of the floating-point unit. Takes a 64-bit operand word holding a double or a left-justified single and produces sign, exponent field, flags, fraction field, a 53-bit significand and its leading-zero count. Downstream adder, multiplier and divider stages consume these outputs. The significand is optionally normalized for denormal handling.

## Interface
- No parameters; all widths are fixed by the double format.
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- fp  in  64  operand; double in [63:0], single in [63:32], and [31:0] is ignored for a single
- db  in  1  1 = double, 0 = single
- normal  in  1  1 = output f left-normalized by lz
- s  out  1  sign
- e  out  11  biased exponent field, zero-extended for a single
- e_inf  out  1  exponent field all ones
- e_z  out  1  exponent field all zeros
- h  out  52  fraction field, left-justified
- fz  out  1  fraction field all zeros
- f  out  53  significand {hidden, h}, normalized when normal=1
- lz  out  6  leading zeros of unnormalized {hidden, h}, range 0..53

## Operation
- Double (db=1): s=fp[63], exponent=fp[62:52], h=fp[51:0].
- Single (db=0): s=fp[63], exponent=fp[62:55], h={fp[54:32], 29'b0}, e={3'b0, exponent}.
- e_inf: 11 ones for a double, 8 ones for a single.
- e_z: exponent == 0.
- fz: h == 0.
- hidden = ~e_z.
- m = {hidden, h}.
- lz = number of leading zeros of m, counted from bit 52.
  - 0 for a normal number.
  - 53 when m == 0 (zero operand).
- f output:
  - normal=0: f = m.
  - normal=1: f = m << lz, truncated to 53 bits; f = 0 when m == 0.
- e is passed through raw. No rebiasing, and no denormal exponent adjustment; downstream uses lz.
- NaN and Inf are not decoded further; consumers use e_inf, fz and h.

## Timing
- All outputs are registered once: inputs sampled at a rising clk edge appear on outputs after that edge. Latency is 1 cycle, throughput is 1 per cycle.
- No handshake; the register loads every cycle.
- rst_n low clears every output to 0 immediately (s, e, e_inf, e_z, h, fz, f, lz), independent of clk.
- Reset deassertion is synchronized by the codebase's reset bridge; the first load occurs at the first edge with rst_n high.
- Reset asserted mid-stream discards the in-flight operand. The first post-reset output reflects the inputs at the first edge after release.
- db and normal are sampled on the same edge as fp.

## Structure
- Shared FPU package holds:
  - format constants: DBL_EXP_W=11, DBL_FRAC_W=52, SGL_EXP_W=8, SGL_FRAC_W=23, SIG_W=53.
  - an unpacked-operand struct (s, e, e_inf, e_z, h, fz, f, lz) for reuse by other FPU stages.
- Sub-module lzc53: 53-bit leading-zero counter, combinational, output 0..53. It is also reused by the normalizer.
- The normalizing left shifter is a local barrel shifter in this block.

## Test plan
- Single 1.0: fp={1'b0, 8'h7F, 23'b0, 32'b0}, db=0, normal=0.
  - Required next cycle: s=0, e=11'h07F, e_z=0, e_inf=0, fz=1, h=0, f=53'h10000000000000, lz=0.
- Single smallest denormal: exponent 0, f32=1, db=0.
  - h has only bit 29 set, lz=23.
  - With normal=0: f has only bit 29 set.
  - With normal=1: f=53'h10000000000000.
- Double +Inf and NaN: fp=64'h7FF0000000000000, db=1.
  - Required: e=11'h7FF, e_inf=1, fz=1, f=53'h10000000000000.
  - With fp=64'h7FF8000000000000: fz=0, h[51]=1.
- Zeros: fp=64'h8000000000000000, db=1 and db=0, normal=1.
  - Required for both: s=1, e=0, e_z=1, fz=1, f=0, lz=53.
- Single −3.5: fp[63:32]=32'hC0600000, with fp[31:0]=32'hFFFFFFFF as noise that must be ignored, db=0.
  - Required: s=1, e=11'h080, h=52'hC000000000000, f=53'h1C000000000000, lz=0.
- Reset:
  - Assert rst_n low while a valid operand is held; all outputs go to 0 without a clock edge.
  - Release rst_n; outputs reflect the held operand one edge later.
